// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcodes,
// ALU operations and datapath mux selects.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// Combinational ALU operation decode for R-type and I-type arithmetic;
// flags funct3 values the controller does not implement.
module alu_decoder
  import mc_pkg::*;
(
  input  logic       r_type,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_control,
  output logic       supported
);

  // Subtraction exists only in the register form; addi ignores bit 30.
  always_comb begin
    alu_control = ALU_ADD;
    supported   = 1'b1;
    case (funct3)
      3'b000:  alu_control = (r_type && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_control = ALU_SLT;
      3'b110:  alu_control = ALU_OR;
      3'b111:  alu_control = ALU_AND;
      default: supported   = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V style main controller: a state register, a sticky
// illegal-opcode flag, and outputs decoded from state, mem_ready and zero.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic [1:0] result_src,
  output logic [3:0] state,
  output logic       illegal
);

  state_t     state_q, next_state;
  logic       illegal_q;
  logic [2:0] dec_alu;
  logic       dec_ok;
  logic       is_store;

  alu_decoder u_alu_decoder (
    .r_type     (opcode == OP_RTYPE),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .alu_control(dec_alu),
    .supported  (dec_ok)
  );

  assign is_store = (opcode == OP_STORE);
  assign state    = state_q;
  assign illegal  = illegal_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= next_state;
      if (next_state == TRAP) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    next_state  = state_q;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    alu_control = ALU_ADD;
    imm_src     = IMM_I;
    result_src  = RES_ALUOUT;
    case (state_q)
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) next_state = DECODE;
      end
      DECODE: begin
        // Branch target is computed here so BEQ can load it straight from ALUOut.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_B;
        case (opcode)
          OP_LOAD, OP_STORE: next_state = MEMADR;
          OP_RTYPE:          next_state = dec_ok ? EXECR : TRAP;
          OP_ITYPE:          next_state = dec_ok ? EXECI : TRAP;
          OP_BRANCH:         next_state = BEQ;
          OP_JAL:            next_state = JAL;
          default:           next_state = TRAP;
        endcase
      end
      MEMADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        imm_src    = is_store ? IMM_S : IMM_I;
        next_state = is_store ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) next_state = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        result_src = RES_DATA;
        next_state = FETCH;
      end
      MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) next_state = FETCH;
      end
      EXECR: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_RS2;
        alu_control = dec_alu;
        next_state  = ALUWB;
      end
      EXECI: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_IMM;
        imm_src     = IMM_I;
        alu_control = dec_alu;
        next_state  = ALUWB;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        result_src = RES_ALUOUT;
        next_state = FETCH;
      end
      BEQ: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_RS2;
        alu_control = ALU_SUB;
        result_src  = RES_ALUOUT;
        pc_write    = zero;
        next_state  = FETCH;
      end
      JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        imm_src    = IMM_J;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        next_state = FETCH;
      end
      TRAP:    next_state = TRAP;
      default: next_state = TRAP;
    endcase
    // Side-effecting enables stay quiet for the whole reset cycle.
    if (!rst) begin
      mem_req   = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

endmodule
